vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Arbitrates the single 14-bit PPU VRAM port between the rendering FSM (`ppu_fsm`) and the CPU data-port registers ($2006 PPUADDR, $2007 PPUDATA).
- Owns the CPU-side VRAM address register, the two-write address latch toggle, the PPUDATA read buffer and auto-increment.
- Sits between `ppu_fsm`, the CPU register decoder and the `generic_ram` VRAM instance.
- Guarantees that rendering fetches are never delayed by CPU traffic while rendering is active.

## Interface
Parameters:
- ADDR_W, 14, VRAM address width (16 KiB)
- DATA_W, 8, VRAM data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rendering  in  1  high: PPU has absolute priority
- inc32  in  1  ppu_ctrl1[2]; 0 → increment 1, 1 → increment 32
- ppu_req  in  1  PPU fetch request, level
- ppu_addr  in  ADDR_W  PPU fetch address
- ppu_grant  out  1  PPU owns the port this cycle (combinational)
- ppu_rvalid  out  1  registered `ppu_grant`; `ppu_rdata` is valid
- ppu_rdata  out  DATA_W  passthrough of `vram_rdata`
- cpu_wr  in  1  one-cycle CPU register write strobe
- cpu_rd  in  1  one-cycle CPU register read strobe
- cpu_reg  in  3  register index (2 = status, 6 = addr, 7 = data)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read buffer contents
- cpu_busy  out  1  CPU access pending or in flight
- overrun  out  1  sticky; a CPU access was dropped
- vram_addr  out  ADDR_W  to RAM
- vram_wdata  out  DATA_W  to RAM
- vram_we  out  1  to RAM
- vram_rdata  in  DATA_W  from RAM, 1-cycle synchronous read latency

## Operation
- **Registers:**
  - v[13:0]: CPU address.
  - w: write toggle.
  - buf[7:0]: read buffer.
  - pend_op: NONE/RD/WR, with pend_data.
- **$2006 write (cpu_wr, reg 6, not busy):**
  - w=0: v[13:8] ← wdata[5:0], w ← 1.
  - w=1: v[7:0] ← wdata, w ← 0.
  - No RAM access.
- **$2002 read (cpu_rd, reg 2):** w ← 0 in all states. Status data is sourced elsewhere.
- **$2007 write (not busy):** pend_op ← WR, pend_data ← wdata, go to WAIT.
- **$2007 read (not busy):**
  - cpu_rdata already shows the old buf.
  - pend_op ← RD, go to WAIT.
- Any reg 6 or reg 7 access while cpu_busy=1 is ignored and sets overrun. Accesses to other registers are ignored here.
- **States:** IDLE, WAIT, ISSUE, CAPTURE.
  - IDLE → WAIT on an accepted $2007 access.
  - WAIT → ISSUE when the CPU wins arbitration, else stay.
  - ISSUE: vram_addr=v; vram_we=1 and vram_wdata=pend_data for WR; v ← v+inc. WR → IDLE; RD → CAPTURE.
  - CAPTURE: buf ← vram_rdata → IDLE.
- **Arbitration per cycle:**
  - rendering=1: PPU wins whenever ppu_req=1.
  - rendering=0: a CPU access in WAIT wins over ppu_req.
  - PPU wins otherwise if ppu_req=1.
  - CAPTURE does not use the port, so the PPU may be granted then.
- **Port mux:**
  - ppu_grant=1 → vram_addr=ppu_addr, vram_we=0.
  - Idle port → vram_addr holds its last value, vram_we=0.
- **Address arithmetic:** v increments modulo 2^14. 0x3FFF+1 → 0x0000; 0x3FF0+32 → 0x0010.
- cpu_busy = (state ≠ IDLE).

## Timing
- **Reset (asynchronous, immediate):** state=IDLE, v=0, w=0, buf=0, overrun=0, vram_we=0, vram_addr=0, ppu_grant=0, ppu_rvalid=0, cpu_busy=0, cpu_rdata=0.
- **Reset mid-operation:** a pending or in-flight write is abandoned. vram_we falls in the same instant.
- **PPU fetch:**
  - Request in cycle N, granted → address on the RAM port in cycle N.
  - Data and ppu_rvalid=1 in N+1.
  - Back-to-back grants give one fetch per cycle.
- **CPU access:**
  - Strobe in cycle N → WAIT in N+1.
  - Earliest ISSUE in N+2; a read captures in N+3 and buf/cpu_rdata update at the end of N+3.
  - cpu_busy is high from N+1 through the last non-IDLE cycle.
- **Simultaneous $2002 read and $2006 write in one cycle:** the $2006 write uses the pre-clear w, then w ← 0.
- A CPU access stalled by rendering waits indefinitely. No timeout.

## Test plan
- **Address latch:** after reset, write $2006=0x21 then 0x08, then $2007=0x5A.
  - RAM[0x2108]=0x5A; v=0x2109; vram_we high for exactly 1 cycle, 2 cycles after the strobe.
- **Read buffer:** preload RAM[0x0010]=0xAB, set v=0x0010, then read $2007 twice.
  - First read returns 0x00; second returns 0xAB; v=0x0012.
- **inc32 wrap:** inc32=1, v=0x3FF0, write $2007=0x11.
  - RAM[0x3FF0]=0x11; v=0x0010.
- **Priority under rendering:** rendering=1, ppu_req held high for 50 cycles, issue a $2007 write at cycle 5.
  - PPU granted all 50 cycles; the CPU write issues on the first cycle after ppu_req drops; cpu_busy high throughout.
- **Overrun and toggle:**
  - Issue a second $2007 write while cpu_busy=1 → it is dropped and overrun=1 until reset.
  - Write $2006 once, read $2002, write $2006=0x3F, 0x00 → v=0x3F00.
- **Async reset mid-write:** assert rst during ISSUE.
  - vram_we=0 immediately; after release v=0, cpu_busy=0, overrun=0.

Source files
------------

// File: rtl/vram_port_arbiter_if.sv
// Bundle of PPU fetch, CPU register and VRAM port signals around vram_port_arbiter.
// master: the surrounding system (PPU FSM, CPU decoder, RAM); slave: the arbiter.
interface vram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic              rendering;
  logic              inc32;
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_grant;
  logic              ppu_rvalid;
  logic [DATA_W-1:0] ppu_rdata;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [2:0]        cpu_reg;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_busy;
  logic              overrun;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic              vram_we;
  logic [DATA_W-1:0] vram_rdata;

  modport master (
    output rendering, inc32, ppu_req, ppu_addr, cpu_wr, cpu_rd, cpu_reg, cpu_wdata, vram_rdata,
    input  ppu_grant, ppu_rvalid, ppu_rdata, cpu_rdata, cpu_busy, overrun,
    input  vram_addr, vram_wdata, vram_we
  );

  modport slave (
    input  rendering, inc32, ppu_req, ppu_addr, cpu_wr, cpu_rd, cpu_reg, cpu_wdata, vram_rdata,
    output ppu_grant, ppu_rvalid, ppu_rdata, cpu_rdata, cpu_busy, overrun,
    output vram_addr, vram_wdata, vram_we
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares the single VRAM port between PPU rendering fetches and CPU $2006/$2007 traffic.
// Holds the CPU address register, write toggle, PPUDATA read buffer and auto-increment.
module vram_port_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  vram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StIssue, StCapture} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] v_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] v_inc;
  logic [ADDR_W-1:0] vram_addr_mux;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              w_q;
  logic              pend_wr_q;
  logic              overrun_q;
  logic              rvalid_q;

  logic busy;
  logic cpu_claim;
  logic issue_go;
  logic ppu_grant;
  logic cpu_acc;
  logic hit_67;
  logic wr_6;
  logic acc_7;
  logic clr_w;

  assign busy    = (state_q != StIdle);
  assign cpu_acc = bus.cpu_wr || bus.cpu_rd;
  assign hit_67  = cpu_acc && ((bus.cpu_reg == 3'd6) || (bus.cpu_reg == 3'd7));
  assign wr_6    = bus.cpu_wr && (bus.cpu_reg == 3'd6) && !busy;
  assign acc_7   = cpu_acc && (bus.cpu_reg == 3'd7) && !busy;
  assign clr_w   = bus.cpu_rd && (bus.cpu_reg == 3'd2);

  // The CPU claims the port in WAIT and ISSUE unless rendering needs it this cycle, so an
  // ISSUE that collides with a rendering fetch simply retries next cycle.
  assign cpu_claim = ((state_q == StWait) || (state_q == StIssue)) &&
                     !(bus.rendering && bus.ppu_req);
  assign issue_go  = (state_q == StIssue) && cpu_claim;
  assign ppu_grant = !rst && bus.ppu_req && !cpu_claim;
  assign v_inc     = bus.inc32 ? ADDR_W'(32) : ADDR_W'(1);

  always_comb begin
    vram_addr_mux = addr_q;
    if (ppu_grant) begin
      vram_addr_mux = bus.ppu_addr;
    end else if (issue_go) begin
      vram_addr_mux = v_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      v_q         <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      pend_data_q <= '0;
      w_q         <= 1'b0;
      pend_wr_q   <= 1'b0;
      overrun_q   <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      addr_q   <= vram_addr_mux;
      rvalid_q <= ppu_grant;
      if (hit_67 && busy) begin
        overrun_q <= 1'b1;
      end
      if (wr_6) begin
        if (!w_q) begin
          v_q[ADDR_W-1:DATA_W] <= bus.cpu_wdata[ADDR_W-DATA_W-1:0];
          w_q                  <= 1'b1;
        end else begin
          v_q[DATA_W-1:0] <= bus.cpu_wdata;
          w_q             <= 1'b0;
        end
      end
      // Placed after the $2006 update so a same-cycle status read always leaves w cleared.
      if (clr_w) begin
        w_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (acc_7) begin
            state_q     <= StWait;
            pend_wr_q   <= bus.cpu_wr;
            pend_data_q <= bus.cpu_wdata;
          end
        end
        StWait: begin
          if (cpu_claim) begin
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (issue_go) begin
            v_q     <= v_q + v_inc;
            state_q <= pend_wr_q ? StIdle : StCapture;
          end
        end
        StCapture: begin
          buf_q   <= bus.vram_rdata;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ppu_grant  = ppu_grant;
  assign bus.ppu_rvalid = rvalid_q;
  assign bus.ppu_rdata  = bus.vram_rdata;
  assign bus.cpu_rdata  = buf_q;
  assign bus.cpu_busy   = busy;
  assign bus.overrun    = overrun_q;
  assign bus.vram_addr  = vram_addr_mux;
  assign bus.vram_wdata = pend_data_q;
  assign bus.vram_we    = issue_go && pend_wr_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter: directed CPU/PPU traffic against a behavioural VRAM.
module tb_vram_port_arbiter;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_wdata;
    bus.vram_rdata <= mem[bus.vram_addr];
  end

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] ppu_q[$];
  int checks = 0;
  int errors = 0;
  wr_t        mon_w;
  logic [7:0] mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ppu_pat(input logic [13:0] a);
    return a[7:0] ^ 8'h5C;
  endfunction

  task automatic exp_wr(input logic [13:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, a read result or a PPU datum.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vram_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write 0x%0h@0x%0h expected none",
                   bus.vram_wdata, bus.vram_addr);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", 32'(bus.vram_addr), 32'(mon_w.addr));
          chk("wr_data", 32'(bus.vram_wdata), 32'(mon_w.data));
        end
      end
      if (bus.cpu_rd && bus.cpu_reg == 3'd7 && !bus.cpu_busy) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got read 0x%0h expected none", bus.cpu_rdata);
        end else begin
          mon_d = rd_q.pop_front();
          chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(mon_d));
        end
      end
      if (bus.ppu_rvalid) begin
        if (ppu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ppu_unexpected: got rvalid data 0x%0h expected none", bus.ppu_rdata);
        end else begin
          mon_d = ppu_q.pop_front();
          chk("ppu_rdata", 32'(bus.ppu_rdata), 32'(mon_d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wr, input logic [2:0] r, input logic [7:0] d);
    bus.cpu_wr    = wr;
    bus.cpu_rd    = !wr;
    bus.cpu_reg   = r;
    bus.cpu_wdata = d;
    tick();
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.cpu_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_idle: got cpu_busy stuck for %0d cycles expected release", n);
    end
  endtask

  int grants;
  int busy_cnt;

  initial begin
    bus.rendering = 1'b0;
    bus.inc32     = 1'b0;
    bus.ppu_req   = 1'b1;
    bus.ppu_addr  = 14'h1234;
    bus.cpu_wr    = 1'b0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_reg   = 3'd0;
    bus.cpu_wdata = 8'h00;

    // Reset values, with a PPU request pending that must not be granted.
    #12;
    chk("rst_grant", 32'(bus.ppu_grant), 0);
    chk("rst_we", 32'(bus.vram_we), 0);
    chk("rst_addr", 32'(bus.vram_addr), 0);
    chk("rst_busy", 32'(bus.cpu_busy), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_rvalid", 32'(bus.ppu_rvalid), 0);
    chk("rst_rdata", 32'(bus.cpu_rdata), 0);
    bus.ppu_req = 1'b0;
    tick();
    rst = 1'b0;

    // Preload read-buffer data and the PPU fetch pattern.
    pre_we = 1'b1;
    pre_addr = 14'h0010; pre_data = 8'hAB; tick();
    pre_addr = 14'h0011; pre_data = 8'hCD; tick();
    for (int i = 0; i < 50; i++) begin
      pre_addr = 14'h0100 + 14'(i);
      pre_data = ppu_pat(pre_addr);
      tick();
    end
    pre_we = 1'b0;

    // Address latch and write timing.
    cpu_access(1'b1, 3'd6, 8'h21);
    cpu_access(1'b1, 3'd6, 8'h08);
    exp_wr(14'h2108, 8'h5A);
    cpu_access(1'b1, 3'd7, 8'h5A);
    @(negedge clk);
    chk("t1_busy_n1", 32'(bus.cpu_busy), 1);
    chk("t1_we_n1", 32'(bus.vram_we), 0);
    tick();
    @(negedge clk);
    chk("t1_we_n2", 32'(bus.vram_we), 1);
    tick();
    @(negedge clk);
    chk("t1_we_n3", 32'(bus.vram_we), 0);
    chk("t1_busy_n3", 32'(bus.cpu_busy), 0);
    tick();
    exp_wr(14'h2109, 8'h77);
    cpu_access(1'b1, 3'd7, 8'h77);
    wait_idle();

    // Read buffer: old buffer first, then prefetched data.
    cpu_access(1'b1, 3'd6, 8'h00);
    cpu_access(1'b1, 3'd6, 8'h10);
    rd_q.push_back(8'h00);
    cpu_access(1'b0, 3'd7, 8'h00);
    wait_idle();
    rd_q.push_back(8'hAB);
    cpu_access(1'b0, 3'd7, 8'h00);
    wait_idle();
    exp_wr(14'h0012, 8'h3C);
    cpu_access(1'b1, 3'd7, 8'h3C);
    wait_idle();
    rd_q.push_back(8'hCD);
    cpu_access(1'b0, 3'd7, 8'h00);
    wait_idle();

    // inc32 wrap and +1 wrap.
    bus.inc32 = 1'b1;
    cpu_access(1'b1, 3'd6, 8'h3F);
    cpu_access(1'b1, 3'd6, 8'hF0);
    exp_wr(14'h3FF0, 8'h11);
    cpu_access(1'b1, 3'd7, 8'h11);
    wait_idle();
    exp_wr(14'h0010, 8'h22);
    cpu_access(1'b1, 3'd7, 8'h22);
    wait_idle();
    bus.inc32 = 1'b0;
    cpu_access(1'b1, 3'd6, 8'h3F);
    cpu_access(1'b1, 3'd6, 8'hFF);
    exp_wr(14'h3FFF, 8'h33);
    cpu_access(1'b1, 3'd7, 8'h33);
    wait_idle();
    exp_wr(14'h0000, 8'h44);
    cpu_access(1'b1, 3'd7, 8'h44);
    wait_idle();

    // Rendering priority: 50 fetches with a CPU write queued at cycle 5.
    bus.rendering = 1'b1;
    grants = 0;
    busy_cnt = 0;
    exp_wr(14'h0001, 8'h99);
    for (int i = 0; i < 50; i++) begin
      bus.ppu_req   = 1'b1;
      bus.ppu_addr  = 14'h0100 + 14'(i);
      bus.cpu_wr    = (i == 5);
      bus.cpu_reg   = 3'd7;
      bus.cpu_wdata = 8'h99;
      ppu_q.push_back(ppu_pat(bus.ppu_addr));
      @(negedge clk);
      if (bus.ppu_grant === 1'b1) grants++;
      if (i > 5 && bus.cpu_busy === 1'b1) busy_cnt++;
      tick();
    end
    bus.cpu_wr  = 1'b0;
    bus.ppu_req = 1'b0;
    @(negedge clk);
    chk("t4_we_at_drop", 32'(bus.vram_we), 0);
    tick();
    @(negedge clk);
    chk("t4_we_after_drop", 32'(bus.vram_we), 1);
    tick();
    wait_idle();
    chk("t4_grants", 32'(grants), 50);
    chk("t4_busy_cycles", 32'(busy_cnt), 44);
    bus.rendering = 1'b0;

    // Overrun on a busy access, and the status-read toggle reset.
    exp_wr(14'h0002, 8'h55);
    cpu_access(1'b1, 3'd7, 8'h55);
    cpu_access(1'b1, 3'd7, 8'h66);
    wait_idle();
    chk("t5_overrun", 32'(bus.overrun), 1);
    cpu_access(1'b1, 3'd6, 8'h12);
    cpu_access(1'b0, 3'd2, 8'h00);
    cpu_access(1'b1, 3'd6, 8'h3F);
    cpu_access(1'b1, 3'd6, 8'h00);
    exp_wr(14'h3F00, 8'hA1);
    cpu_access(1'b1, 3'd7, 8'hA1);
    wait_idle();
    chk("t5_overrun_sticky", 32'(bus.overrun), 1);

    // Asynchronous reset while a write is on the port.
    cpu_access(1'b1, 3'd7, 8'hB2);
    tick();
    chk("t6_we_issue", 32'(bus.vram_we), 1);
    bus.ppu_req  = 1'b1;
    bus.ppu_addr = 14'h0155;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_we_rst", 32'(bus.vram_we), 0);
    chk("t6_addr_rst", 32'(bus.vram_addr), 0);
    chk("t6_busy_rst", 32'(bus.cpu_busy), 0);
    chk("t6_grant_rst", 32'(bus.ppu_grant), 0);
    chk("t6_overrun_rst", 32'(bus.overrun), 0);
    bus.ppu_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("t6_rdata_rst", 32'(bus.cpu_rdata), 0);
    exp_wr(14'h0000, 8'hC4);
    cpu_access(1'b1, 3'd7, 8'hC4);
    wait_idle();
    chk("t6_overrun_after", 32'(bus.overrun), 0);

    repeat (4) tick();
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("rd_q_empty", 32'(rd_q.size()), 0);
    chk("ppu_q_empty", 32'(ppu_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
